// File: rtl/truth_table_scanner.sv
// Drives all 32 input vectors to an external 5-input function, samples F for each
// vector after a settle delay, and reports the captured table, its minterm count and a golden match.
module truth_table_scanner #(
    parameter int unsigned SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        f_in,
    input  logic [31:0] expected,
    output logic [4:0]  abcde,
    output logic        busy,
    output logic        done,
    output logic [31:0] table_out,
    output logic [5:0]  ones_cnt,
    output logic        match
);

    typedef enum logic [1:0] {StIdle, StSettle, StSample, StFinish} state_t;

    localparam logic [3:0] SettleLoad = 4'(SETTLE - 1);

    state_t      state;
    logic [4:0]  idx;
    logic [3:0]  cnt;
    logic [31:0] acc;
    logic [31:0] acc_next;
    logic [5:0]  ones;
    logic [5:0]  ones_next;

    // Accumulator including the bit being sampled this cycle, so FINISH sees vector 31.
    always_comb begin
        acc_next      = acc;
        acc_next[idx] = f_in;
        ones_next     = ones + {5'd0, f_in};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            idx       <= 5'd0;
            cnt       <= 4'd0;
            acc       <= 32'd0;
            ones      <= 6'd0;
            abcde     <= 5'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            table_out <= 32'd0;
            ones_cnt  <= 6'd0;
            match     <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (start) begin
                        state <= StSettle;
                        idx   <= 5'd0;
                        cnt   <= SettleLoad;
                        acc   <= 32'd0;
                        ones  <= 6'd0;
                        abcde <= 5'd0;
                        busy  <= 1'b1;
                    end
                end
                StSettle: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state <= StSample;
                    end
                end
                StSample: begin
                    acc  <= acc_next;
                    ones <= ones_next;
                    if (idx != 5'd31) begin
                        idx   <= idx + 5'd1;
                        abcde <= idx + 5'd1;
                        cnt   <= SettleLoad;
                        state <= StSettle;
                    end else begin
                        idx       <= 5'd0;
                        abcde     <= 5'd0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        table_out <= acc_next;
                        ones_cnt  <= ones_next;
                        match     <= (acc_next == expected);
                        state     <= StFinish;
                    end
                end
                StFinish: begin
                    done  <= 1'b0;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/truth_table_scanner.md
TRUTH_TABLE_SCANNER -- requirements
Module: truth_table_scanner

Interface
REQ-001 SHALL have parameter SETTLE, default 1, meaning cycles each input vector is held before F is sampled; legal 1..15.
REQ-002 SHALL have port clk  input  1  single system clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port start  input  1  request to begin a full 32-vector scan.
REQ-005 SHALL have port f_in  input  1  output F of the external 5-input combinational function under test.
REQ-006 SHALL have port abcde  output  5  vector driven to the function inputs; bit4=A, bit3=B, bit2=C, bit1=D, bit0=E.
REQ-007 SHALL have port expected  input  32  golden truth table; bit i = required F for abcde=i.
REQ-008 SHALL have port busy  output  1  high while a scan is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse marking scan completion.
REQ-010 SHALL have port table_out  output  32  captured truth table; bit i = F sampled for abcde=i.
REQ-011 SHALL have port ones_cnt  output  6  number of minterms (set bits in table_out), 0..32.
REQ-012 SHALL have port match  output  1  high when table_out equals expected.

Function
REQ-013 SHALL implement FSM states IDLE, SETTLE, SAMPLE, FINISH.
REQ-014 IDLE: abcde=0, busy=0, done=0; start=1 at a clock edge -> SETTLE with idx=0, settle counter=SETTLE-1, internal accumulator and count cleared.
REQ-015 SETTLE: abcde=idx, busy=1; counter!=0 -> decrement, stay; counter==0 -> SAMPLE. Each vector SHALL therefore be held SETTLE cycles in SETTLE.
REQ-016 SAMPLE: abcde=idx, busy=1; at the edge leaving SAMPLE, f_in SHALL be written to accumulator bit idx and the count incremented when f_in=1.
REQ-017 SAMPLE with idx<31 -> idx+1, counter reloaded to SETTLE-1, -> SETTLE; idx==31 -> FINISH.
REQ-018 On the edge entering FINISH, table_out, ones_cnt and match SHALL load the final accumulator, final count (6-bit, no overflow at 32) and (accumulator==expected), expected sampled at that edge.
REQ-019 FINISH: done=1, busy=0, abcde=0, for exactly one cycle, then -> IDLE.
REQ-020 Latency: first cycle with done=1 SHALL occur 32*(SETTLE+1)+1 cycles after the edge that accepted start.
REQ-021 table_out, ones_cnt, match SHALL hold their values from FINISH until the next FINISH; a new scan SHALL NOT disturb them before it completes.
REQ-022 start SHALL be ignored in SETTLE, SAMPLE and FINISH; start held high continuously SHALL begin a new scan on the edge after FINISH returns to IDLE.
REQ-023 idx SHALL be 5 bits and never wrap past 31 within a scan.
REQ-024 f_in SHALL be sampled only in SAMPLE; glitches in SETTLE SHALL have no effect.

Reset
REQ-025 rst_n=0 SHALL immediately, regardless of clock, force state IDLE, idx=0, counter=0, abcde=0, busy=0, done=0, table_out=0, ones_cnt=0, match=0, accumulator=0.
REQ-026 Reset asserted mid-scan SHALL abort the scan with no done pulse; after release, a new start SHALL be required.
REQ-027 First start accepted SHALL be at the first rising edge with rst_n=1 and start=1.

Verification
REQ-028 f_in tied 1, expected=32'hFFFF_FFFF, SETTLE=1, start pulse -> done after 65 cycles, table_out=32'hFFFF_FFFF, ones_cnt=32, match=1.
REQ-029 f_in=abcde[0], expected=32'hAAAA_AAAA -> table_out=32'hAAAA_AAAA, ones_cnt=16, match=1; repeat with expected=32'h5555_5555 -> match=0.
REQ-030 f_in=(abcde==31), SETTLE=3 -> done 129 cycles after start, table_out=32'h8000_0000, ones_cnt=1; abcde sequence 0..31, each value held 4 cycles.
REQ-031 rst_n pulsed low at idx=10 during scan -> all outputs 0 asynchronously, no done, busy=0; subsequent start completes a full scan normally.
REQ-032 start held high throughout -> done pulses every 32*(SETTLE+1)+2 cycles; start pulses during busy produce no extra scans and no change in timing.
